// File: rtl/mips_pkg.sv
// Shared definitions for the fetch slice: datapath width, memory depth,
// reset vector and the fetch FSM state encoding.
package mips_pkg;

    localparam int          MIPS_WIDTH    = 32;
    localparam int          MIPS_DEPTH    = 256;
    localparam logic [31:0] MIPS_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // Highest word-aligned byte address inside a memory of `depth` words.
    function automatic int pc_max(input int depth);
        return depth * 4 - 4;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control and status bundle between the fetch unit and its controller.
// The controller is the master; the fetch unit is the slave.
interface pc_fetch_unit_if #(
    parameter int WIDTH = mips_pkg::MIPS_WIDTH
);
    logic             start;
    logic             stall;
    logic             branch;
    logic [WIDTH-1:0] imm_ext;
    logic             jump;
    logic [25:0]      jump_target;
    logic [WIDTH-1:0] pc_A;
    logic [WIDTH-1:0] pc_plus4;
    logic             running;
    logic             halted;
    logic             range_err;
    logic [31:0]      fetch_count;

    modport master (
        output start, stall, branch, imm_ext, jump, jump_target,
        input  pc_A, pc_plus4, running, halted, range_err, fetch_count
    );

    modport slave (
        input  start, stall, branch, imm_ext, jump, jump_target,
        output pc_A, pc_plus4, running, halted, range_err, fetch_count
    );
endinterface

// File: rtl/npc_logic.sv
// Next-PC selection (jump over branch over sequential) and the check that
// the selected address lies inside instruction memory.
module npc_logic
    import mips_pkg::*;
#(
    parameter int WIDTH = MIPS_WIDTH,
    parameter int DEPTH = MIPS_DEPTH
) (
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic             branch,
    input  logic [WIDTH-1:0] imm_ext,
    input  logic             jump,
    input  logic [25:0]      jump_target,
    output logic [WIDTH-1:0] npc,
    output logic             out_of_range
);

    localparam logic [WIDTH-1:0] PC_MAX = WIDTH'(pc_max(DEPTH));

    // Select the candidate PC and flag it when it falls past the last word.
    always_comb begin
        npc = pc_plus4;
        if (jump) begin
            npc = {pc_plus4[WIDTH-1:28], jump_target, 2'b00};
        end else if (branch) begin
            npc = pc_plus4 + (imm_ext << 2);
        end
        out_of_range = (npc > PC_MAX);
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: IDLE/RUN/HALT control, the PC register and
// a count of fetches that actually advanced the PC.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter int               WIDTH    = MIPS_WIDTH,
    parameter int               DEPTH    = MIPS_DEPTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(MIPS_RESET_PC)
) (
    input logic         clk,
    input logic         rst_n,
    pc_fetch_unit_if.slave bus
);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [31:0]      count_q, count_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] npc;
    logic             out_of_range;

    assign pc_plus4 = pc_q + WIDTH'(4);

    npc_logic #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_npc (
        .pc_plus4     (pc_plus4),
        .branch       (bus.branch),
        .imm_ext      (bus.imm_ext),
        .jump         (bus.jump),
        .jump_target  (bus.jump_target),
        .npc          (npc),
        .out_of_range (out_of_range)
    );

    // Decide the next state, PC, fetch count and sticky error.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end
            end
            ST_RUN: begin
                if (!bus.stall) begin
                    if (out_of_range) begin
                        state_d = ST_HALT;
                        err_d   = 1'b1;
                    end else if (npc == pc_q) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = npc;
                        count_d = count_q + 32'd1;
                    end
                end
            end
            ST_HALT: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = RESET_PC;
                count_d = '0;
                err_d   = 1'b0;
            end
        endcase
    end

    // State, PC, counter and error registers; reset acts immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registered state is updated with non-blocking assignments only.
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign bus.pc_A        = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.running     = (state_q == ST_RUN);
    assign bus.halted      = (state_q == ST_HALT);
    assign bus.range_err   = err_q;
    assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios with literal
// expectations, then randomized control checked every cycle against a
// behavioural model.
module tb_pc_fetch_unit;

    localparam int          W      = 32;
    localparam int          DEPTH  = 256;
    localparam logic [31:0] LIMIT  = 32'h0000_03FC;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pc_fetch_unit_if #(.WIDTH(W)) bus ();

    pc_fetch_unit #(
        .WIDTH    (W),
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_run, m_halt, m_err;
    logic [31:0] m_pc, m_cnt;

    function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic br,
                                              input logic [31:0] imm, input logic jmp,
                                              input logic [25:0] jt);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        if (jmp) return {p4[31:28], jt, 2'b00};
        if (br)  return p4 + (imm << 2);
        return p4;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run  <= 1'b0;
            m_halt <= 1'b0;
            m_err  <= 1'b0;
            m_pc   <= RST_PC;
            m_cnt  <= 32'd0;
        end else if (!m_run && !m_halt) begin
            if (bus.start) m_run <= 1'b1;
        end else if (m_run) begin
            if (!bus.stall) begin
                if (model_npc(m_pc, bus.branch, bus.imm_ext, bus.jump, bus.jump_target) > LIMIT) begin
                    m_run  <= 1'b0;
                    m_halt <= 1'b1;
                    m_err  <= 1'b1;
                end else if (model_npc(m_pc, bus.branch, bus.imm_ext, bus.jump, bus.jump_target) == m_pc) begin
                    m_run  <= 1'b0;
                    m_halt <= 1'b1;
                end else begin
                    m_pc  <= model_npc(m_pc, bus.branch, bus.imm_ext, bus.jump, bus.jump_target);
                    m_cnt <= m_cnt + 32'd1;
                end
            end
        end else if (bus.start) begin
            m_halt <= 1'b0;
            m_run  <= 1'b1;
            m_pc   <= RST_PC;
            m_cnt  <= 32'd0;
            m_err  <= 1'b0;
        end
    end

    // Every cycle, compare all outputs with the model away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("pc_A",        bus.pc_A,               m_pc);
            check("pc_plus4",    bus.pc_plus4,           m_pc + 32'd4);
            check("running",     32'(bus.running),       32'(m_run));
            check("halted",      32'(bus.halted),        32'(m_halt));
            check("range_err",   32'(bus.range_err),     32'(m_err));
            check("fetch_count", bus.fetch_count,        m_cnt);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic s, input logic st, input logic br, input logic [31:0] imm,
                        input logic j, input logic [25:0] jt);
        @(negedge clk);
        bus.start       = s;
        bus.stall       = st;
        bus.branch      = br;
        bus.imm_ext     = imm;
        bus.jump        = j;
        bus.jump_target = jt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.stall       = 1'b0;
        bus.branch      = 1'b0;
        bus.imm_ext     = 32'd0;
        bus.jump        = 1'b0;
        bus.jump_target = 26'd0;
        rst_n           = 1'b0;
        #12;
        check("rst pc_A",        bus.pc_A,              32'h0);
        check("rst running",     32'(bus.running),      32'd0);
        check("rst halted",      32'(bus.halted),       32'd0);
        check("rst fetch_count", bus.fetch_count,       32'd0);
        check("rst range_err",   32'(bus.range_err),    32'd0);
        chk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Start then three free cycles.
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
        check("start pc_A",    bus.pc_A,         32'h0);
        check("start running", 32'(bus.running), 32'd1);
        idle_step(); check("seq pc 4", bus.pc_A, 32'h4);
        idle_step(); check("seq pc 8", bus.pc_A, 32'h8);
        idle_step(); check("seq pc C", bus.pc_A, 32'hC);
        check("seq count 3", bus.fetch_count, 32'd3);
        idle_step();
        idle_step(); check("seq pc 14", bus.pc_A, 32'h14);

        // Branch, then jump beating branch.
        step(1'b0, 1'b0, 1'b1, 32'd6, 1'b0, 26'd0);
        check("branch pc", bus.pc_A, 32'h30);
        step(1'b0, 1'b0, 1'b1, 32'd6, 1'b1, 26'd5);
        check("jump wins pc", bus.pc_A, 32'h14);

        // Self-loop halt and restart.
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 26'd5);
        check("self halted",    32'(bus.halted),    32'd1);
        check("self pc",        bus.pc_A,           32'h14);
        check("self range_err", 32'(bus.range_err), 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
        check("restart pc",      bus.pc_A,         32'h0);
        check("restart running", 32'(bus.running), 32'd1);
        check("restart count",   bus.fetch_count,  32'd0);
        idle_step();
        check("after restart pc", bus.pc_A, 32'h4);

        // Stall ignores jump and holds the counter.
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 26'd100);
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 26'd100);
        check("stall pc",    bus.pc_A,        32'h4);
        check("stall count", bus.fetch_count, 32'd1);

        // Reach the last word, then run off the end.
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 26'hFF);
        check("last word pc", bus.pc_A, 32'h3FC);
        idle_step();
        check("oor halted",    32'(bus.halted),    32'd1);
        check("oor range_err", 32'(bus.range_err), 32'd1);
        check("oor pc",        bus.pc_A,           32'h3FC);
        check("oor count",     bus.fetch_count,    32'd2);
        idle_step();
        check("halt holds pc", bus.pc_A, 32'h3FC);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
        check("clear range_err", 32'(bus.range_err), 32'd0);
        idle_step();
        idle_step();
        check("rerun pc", bus.pc_A, 32'h8);

        // Mid-run asynchronous reset.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst pc",      bus.pc_A,         32'h0);
        check("async rst running", 32'(bus.running), 32'd0);
        check("async rst count",   bus.fetch_count,  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_step();
        check("idle needs start", 32'(bus.running), 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
        check("run after rst", 32'(bus.running), 32'd1);

        // Randomized control against the model.
        for (int i = 0; i < 3000; i++) begin
            int off;
            @(negedge clk);
            off             = int'($urandom_range(16)) - 8;
            bus.start       = ($urandom_range(15) == 0);
            bus.stall       = ($urandom_range(4) == 0);
            bus.branch      = ($urandom_range(3) == 0);
            bus.imm_ext     = off;
            bus.jump        = ($urandom_range(9) == 0);
            bus.jump_target = 26'($urandom_range(300));
            if ($urandom_range(499) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter WIDTH, default 32: datapath and address width.
REQ-002 Parameter DEPTH, default 256: instruction memory depth in words; the valid PC range is 0 to DEPTH*4-4.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: PC value loaded at reset and restart.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1: reset is asynchronous and active-low.
REQ-006 start  input  1: single-cycle pulse; begins or restarts execution.
REQ-007 stall  input  1: holds the PC for the current cycle.
REQ-008 branch  input  1: conditional branch taken (already resolved by the controller).
REQ-009 imm_ext  input  WIDTH: sign-extended 16-bit branch offset, in words.
REQ-010 jump  input  1: J-type jump.
REQ-011 jump_target  input  26: J-type instruction index field.
REQ-012 pc_A  output  WIDTH: current PC, drives the instruction memory address port.
REQ-013 pc_plus4  output  WIDTH: pc_A + 4.
REQ-014 running  output  1: state is RUN.
REQ-015 halted  output  1: state is HALT.
REQ-016 range_err  output  1: sticky flag; set when the computed next PC is outside the valid range.
REQ-017 fetch_count  output  32: count of advancing RUN cycles.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN and HALT.
REQ-019 IDLE SHALL move to RUN when start=1; otherwise it SHALL hold with pc_A=RESET_PC.
REQ-020 The next-PC value (npc) SHALL be selected with jump having priority over branch:
- jump=1: {pc_plus4[31:28], jump_target, 2'b00}
- else branch=1: pc_plus4 + (imm_ext << 2), modulo 2^WIDTH
- else: pc_plus4
REQ-021 In RUN with stall=1:
- pc_A and fetch_count SHALL hold.
- branch and jump SHALL be ignored.
- No halt condition SHALL be evaluated.
REQ-022 In RUN with stall=0 and npc outside the valid range:
- pc_A SHALL hold.
- range_err SHALL be set to 1.
- The state SHALL move to HALT.
REQ-023 In RUN with stall=0 and npc==pc_A (self-loop), the state SHALL move to HALT, pc_A SHALL be unchanged, and range_err SHALL be unchanged.
REQ-024 Otherwise in RUN with stall=0:
- pc_A SHALL load npc.
- fetch_count SHALL increment by 1, wrapping from 2^32-1 to 0.
REQ-025 HALT SHALL hold pc_A and fetch_count.
REQ-026 start=1 in HALT SHALL, on the next edge:
- load RESET_PC into pc_A;
- clear fetch_count and range_err;
- enter RUN.
REQ-027 start=1 in RUN SHALL be ignored.
REQ-028 pc_A SHALL be registered with 0 combinational latency to the output; the updated PC SHALL be visible in the cycle after the edge.
REQ-029 pc_plus4 SHALL be combinational from pc_A and SHALL wrap modulo 2^WIDTH.

Reset
REQ-030 When rst_n=0, at any time including mid-run, the block SHALL immediately set:
- state=IDLE, pc_A=RESET_PC;
- fetch_count=0, range_err=0;
- running=0, halted=0.
REQ-031 Deassertion of rst_n SHALL take effect only through the synchronous IDLE-to-RUN path (requires start).

Structure
REQ-032 The shared package mips_pkg SHALL hold WIDTH, the DEPTH default, RESET_PC and the FSM state enumeration.
REQ-033 The next-PC mux and range check SHALL be one combinational sub-module, npc_logic; the FSM, PC register and counter SHALL reside in pc_fetch_unit.

Verification
REQ-034 Reset and start: rst_n low then start pulse, three free cycles -> pc_A sequence 0x0, 0x4, 0x8, 0xC; fetch_count=3.
REQ-035 Branch and jump:
- branch=1 with imm_ext=6 at pc_A=0x14 -> pc_A=0x30.
- jump=1 with jump_target=5 and branch=1 in the same cycle -> pc_A=0x14 (jump wins).
REQ-036 Self-loop halt: jump=1, jump_target=5 at pc_A=0x14 -> halted=1 next cycle, pc_A=0x14, range_err=0; start -> pc_A=0x0, running=1.
REQ-037 Out-of-range halt: free-run to pc_A=0x3FC -> next edge halted=1, range_err=1, pc_A=0x3FC.
REQ-038 Stall and mid-run reset:
- stall=1 for 2 cycles with jump=1 -> pc_A and fetch_count unchanged.
- rst_n low mid-RUN between edges -> pc_A=0x0 and state IDLE immediately.
